// File: rtl/adc_spi_cfg_seq.sv
// adc_spi_cfg_seq: streams a list of configuration words from a local register
// file to up to NADC SPI ADCs, either to all unmasked ADCs at once (broadcast)
// or to each unmasked ADC in turn (sequential).
//
// Ports
//   CLK, RST                 clock, synchronous active-low reset
//   INIT, MODE, NWORDS, MASK sequence start and its parameters (sampled in IDLE)
//   WE, WR_ADDR, WR_DATA     register-file write port (any state)
//   RD_ADDR, RD_DATA         registered register-file readback
//   CS, SCLK, SDATA          SPI bus: active-low selects, idle-low clock, MSB-first data
//   BUSY, DONE               sequence in progress / last sequence completed (level)
module adc_spi_cfg_seq #(
    parameter int unsigned NADC     = 12,
    parameter int unsigned WORD_W   = 24,
    parameter int unsigned AW       = 5,
    parameter int unsigned SCLK_DIV = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              INIT,
    input  logic              MODE,
    input  logic [AW:0]       NWORDS,
    input  logic [NADC-1:0]   MASK,
    input  logic              WE,
    input  logic [AW-1:0]     WR_ADDR,
    input  logic [WORD_W-1:0] WR_DATA,
    input  logic [AW-1:0]     RD_ADDR,
    output logic [WORD_W-1:0] RD_DATA,
    output logic [NADC-1:0]   CS,
    output logic              SCLK,
    output logic              SDATA,
    output logic              BUSY,
    output logic              DONE
);

    localparam int unsigned DEPTH    = 1 << AW;
    localparam int unsigned NW       = AW + 1;
    localparam int unsigned AIW      = (NADC > 1) ? $clog2(NADC) : 1;
    localparam int unsigned BIW      = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [7:0]  DIV_LAST = 8'(SCLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP, NEXT, FIN} state_t;

    state_t            state;
    logic [7:0]        div_cnt;
    logic [BIW-1:0]    bit_cnt;
    logic [WORD_W-1:0] shreg;
    logic [NW-1:0]     word_idx;
    logic [AIW-1:0]    adc_idx;
    logic              mode_l;
    logic [NW-1:0]     nwords_l;
    logic [NADC-1:0]   mask_l;

    logic [WORD_W-1:0] mem [DEPTH];

    logic              first_found;
    logic [AIW-1:0]    first_idx;
    logic              seek_found;
    logic [AIW-1:0]    seek_idx;
    logic [NW-1:0]     word_inc;
    logic [NW-1:0]     adv_word;
    logic [AIW-1:0]    adv_adc;
    logic              adv_done;

    // Chip-select pattern for a frame: mask in broadcast, one-hot-low in sequential
    function automatic logic [NADC-1:0] frame_cs(input logic mode, input logic [NADC-1:0] mask,
                                                 input logic [AIW-1:0] idx);
        return mode ? ~(NADC'(1) << idx) : mask;
    endfunction

    // Register file write port; reset blocks writes but never clears contents
    always_ff @(posedge CLK) begin
        if (RST && WE) mem[WR_ADDR] <= WR_DATA;
    end

    // Registered readback with write-through for a same-cycle write
    always_ff @(posedge CLK) begin
        if (!RST)                           RD_DATA <= '0;
        else if (WE && (WR_ADDR == RD_ADDR)) RD_DATA <= WR_DATA;
        else                                RD_DATA <= mem[RD_ADDR];
    end

    // First unmasked ADC of the incoming MASK, and next unmasked ADC above adc_idx
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        seek_found  = 1'b0;
        seek_idx    = '0;
        for (int i = 0; i < int'(NADC); i++) begin
            if (!first_found && !MASK[i]) begin
                first_found = 1'b1;
                first_idx   = AIW'(i);
            end
            if (!seek_found && !mask_l[i] && (i > int'(adc_idx))) begin
                seek_found = 1'b1;
                seek_idx   = AIW'(i);
            end
        end
    end

    // Word/ADC advance evaluated during GAP so the step costs no extra cycle
    always_comb begin
        word_inc = NW'(word_idx + 1'b1);
        adv_word = '0;
        adv_adc  = adc_idx;
        adv_done = 1'b0;
        if (word_inc < nwords_l)        adv_word = word_inc;
        else if (mode_l && seek_found)  adv_adc  = seek_idx;
        else                            adv_done = 1'b1;
    end

    // Sequencer: state, counters and all bus/status outputs registered together.
    // shreg holds the bits still to be sent after SDATA, left-aligned.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            word_idx <= '0;
            adc_idx  <= '0;
            mode_l   <= 1'b0;
            nwords_l <= '0;
            mask_l   <= '0;
            CS       <= '1;
            SCLK     <= 1'b0;
            SDATA    <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (INIT) begin
                        mode_l   <= MODE;
                        nwords_l <= NWORDS;
                        mask_l   <= MASK;
                        BUSY     <= 1'b1;
                        DONE     <= 1'b0;
                        word_idx <= '0;
                        adc_idx  <= first_idx;
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                        if ((NWORDS == '0) || !first_found) begin
                            state <= FIN;
                        end else begin
                            state <= SETUP;
                            shreg <= {mem[0][WORD_W-2:0], 1'b0};
                            SDATA <= mem[0][WORD_W-1];
                            CS    <= frame_cs(MODE, MASK, first_idx);
                        end
                    end
                end
                SETUP: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (!SCLK) begin
                            SCLK <= 1'b1;
                        end else begin
                            // SDATA moves only together with the falling SCLK edge
                            SCLK <= 1'b0;
                            if (bit_cnt == BIW'(WORD_W - 1)) begin
                                SDATA <= 1'b0;
                                state <= HOLD;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                                SDATA   <= shreg[WORD_W-1];
                                shreg   <= {shreg[WORD_W-2:0], 1'b0};
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                HOLD: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        CS      <= '1;
                        state   <= GAP;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                GAP: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (adv_done) begin
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            word_idx <= adv_word;
                            adc_idx  <= adv_adc;
                            shreg    <= {mem[adv_word[AW-1:0]][WORD_W-2:0], 1'b0};
                            SDATA    <= mem[adv_word[AW-1:0]][WORD_W-1];
                            CS       <= frame_cs(mode_l, mask_l, adv_adc);
                            state    <= SETUP;
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                FIN: begin
                    BUSY  <= 1'b0;
                    DONE  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
